mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select: PC, IR, register file, ALU operand muxes, memory port. It takes the IR opcode and the ALU branch-compare result as inputs, and sits beside the datapath that contains the immediate generator, register file and ALU.

## Interface
- MEM_TIMEOUT, 0: cycles to wait for mem_ready before trapping. 0 means wait forever.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- br_taken  in  1  ALU comparator result for the current branch
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid only with mem_req
- addr_sel  out  1  memory address mux: 0=PC, 1=ALUOut
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update gated by br_taken, internal AND, exported for debug
- pc_src  out  2  PC mux: 0=ALU result, 1=ALUOut, 2=reserved
- reg_write  out  1  register file write enable
- wb_sel  out  2  writeback mux: 0=ALUOut, 1=mem data, 2=PC (link)
- alu_src_a  out  2  ALU A mux: 0=PC, 1=rs1, 2=old PC
- alu_src_b  out  2  ALU B mux: 0=rs2, 1=const 4, 2=immediate
- alu_op  out  2  0=add, 1=sub/compare, 2=funct-decoded
- illegal  out  1  sticky unsupported-opcode or timeout flag
- state_dbg  out  4  current state encoding

## Operation
- Moore FSM. All outputs decode from the current state only, except ir_write and pc_write in FETCH, which are qualified by mem_ready.
- States and transitions:
  - IDLE, the reset state: all outputs 0. Next cycle goes to FETCH.
  - FETCH: mem_req=1, addr_sel=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0. While mem_ready=0, hold. On mem_ready=1, assert ir_write and pc_write (PC<=PC+4) and go to DECODE.
  - DECODE: alu_src_a=2, alu_src_b=2, alu_op=0, which latches the branch/jump target old PC+imm into ALUOut. Next state by opcode: 0010011 → EXEC; 0000011 or 0100011 → ADDR; 1100011 → BRANCH; 1101111 → JAL; anything else → TRAP.
  - EXEC: alu_src_a=1, alu_src_b=2, alu_op=2. Next is ALU_WB.
  - ALU_WB: reg_write=1, wb_sel=0. Next is FETCH.
  - ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next is MEM_RD for LOAD, MEM_WR for STORE.
  - MEM_RD: mem_req=1, addr_sel=1. Hold until mem_ready, then go to LOAD_WB.
  - LOAD_WB: reg_write=1, wb_sel=1. Next is FETCH.
  - MEM_WR: mem_req=1, mem_we=1, addr_sel=1. Hold until mem_ready, then go to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_write_cond=1. PC updates only when br_taken=1. Next is FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=1. Next is FETCH.
  - TRAP: all enables 0, illegal=1. Absorbing until reset.
- Memory handshake:
  - Once mem_req rises, it stays high, and addr_sel and mem_we stay stable, until a cycle with mem_ready=1. That cycle completes the transfer.
  - mem_ready sampled while mem_req=0 is ignored.
  - Back-to-back requests are legal. MEM_WR→FETCH gives mem_req=1 on consecutive cycles.
- Timeout: when MEM_TIMEOUT>0, a wait counter runs in FETCH, MEM_RD and MEM_WR. It clears on entry and on mem_ready. When it reaches MEM_TIMEOUT, the FSM goes to TRAP. A mem_ready arriving in that same cycle wins.
- illegal is sticky. Only rst_n clears it.

## Timing
- Reset: asynchronous assertion forces IDLE immediately, all outputs 0, counters 0. This applies mid-transfer too; the memory must tolerate mem_req dropping.
- Deassertion is synchronized externally. The first active edge after deassertion moves to FETCH.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, ALU_WB)
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles
  - JAL: 3 cycles
- Each memory wait cycle adds 1 cycle.
- Registered writes take effect at the clock edge that leaves the state.

## Configuration
- MC_CTRL_PERF_EN defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle outside IDLE and TRAP.
  - instret_cnt increments on every transition into FETCH from a non-IDLE state.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Shared package mc_pkg holds:
  - the opcode constants: OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL
  - the state enum
  - the encodings for alu_op, wb_sel, pc_src and the ALU-mux selects
- The datapath imports the same package.
- Optional sub-module mc_mem_wait holds the handshake/timeout counter. The FSM core stays in mc_ctrl_fsm.

## Test plan
- Reset, then rst_n released with opcode=0010011 and mem_ready=1 → state_dbg sequence IDLE, FETCH, DECODE, EXEC, ALU_WB, FETCH. ir_write=1 for exactly one cycle, reg_write=1 only in ALU_WB.
- LOAD (0000011) with mem_ready low for 3 cycles in MEM_RD → mem_req, addr_sel=1 held stable 4 cycles. LOAD_WB has wb_sel=1. Total 8 cycles.
- BRANCH (1100011) run twice, br_taken=0 then 1 → PC updates only in the taken case. 3 cycles each.
- JAL (1101111) → JAL state asserts reg_write=1, wb_sel=2, pc_write=1 together. Next state FETCH.
- opcode=0110111 → TRAP after DECODE, illegal=1 and held for 100 cycles. rst_n low clears it.
- rst_n asserted while in MEM_WR mid-wait → mem_req and mem_we drop the same cycle, state IDLE. With MC_CTRL_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control path and its datapath.
// Pure constants/types; no latency, no backpressure.
package mc_pkg;

  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC    = 4'd3,
    ST_ALU_WB  = 4'd4,
    ST_ADDR    = 4'd5,
    ST_MEM_RD  = 4'd6,
    ST_LOAD_WB = 4'd7,
    ST_MEM_WR  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JAL     = 4'd10,
    ST_TRAP    = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;

  localparam logic [1:0] PC_ALU     = 2'd0;
  localparam logic [1:0] PC_ALUOUT  = 2'd1;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

  function automatic logic is_mem_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait counter: flags a timeout after MEM_TIMEOUT unanswered request cycles.
// Latency: combinational flag from registered count; MEM_TIMEOUT=0 disables it (wait forever).
module mc_mem_wait #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  input  logic mem_ready,
  output logic timeout
);

  generate
    if (MEM_TIMEOUT > 0) begin : g_cnt
      localparam int W = $clog2(MEM_TIMEOUT + 1);
      localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
      logic [W-1:0] cnt;

      // count resets whenever the request completes or the state changes
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (!waiting || clear || mem_ready) begin
          cnt <= '0;
        end else if (cnt != LIMIT) begin
          cnt <= cnt + 1'b1;
        end
      end

      // a completing mem_ready in the limit cycle takes priority
      assign timeout = waiting && !mem_ready && (cnt == LIMIT);
    end else begin : g_none
      logic unused_in;
      assign unused_in = &{1'b0, clk, rst_n, waiting, clear, mem_ready};
      assign timeout   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore control sequencer for the multi-cycle RV32I core; optional perf counters under MC_CTRL_PERF_EN.
// Latency 3-5 cycles per instruction plus one per memory wait; memory backpressure via mem_ready hold.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic [3:0]  state_dbg
);

  state_t state, state_next;
  logic   timeout;
  logic   wait_clear;

  // the branch comparator gates the PC enable in the datapath (pc_write_cond & br_taken)
  logic unused_br;
  assign unused_br = br_taken;

  assign wait_clear = (state_next != state);

  mc_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .waiting   (is_mem_wait(state)),
    .clear     (wait_clear),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_next = ST_DECODE;
        else if (timeout) state_next = ST_TRAP;
      end
      ST_DECODE: begin
        case (opcode)
          OP_ITYPE:          state_next = ST_EXEC;
          OP_LOAD, OP_STORE: state_next = ST_ADDR;
          OP_BRANCH:         state_next = ST_BRANCH;
          OP_JAL:            state_next = ST_JAL;
          default:           state_next = ST_TRAP;
        endcase
      end
      ST_EXEC:    state_next = ST_ALU_WB;
      ST_ALU_WB:  state_next = ST_FETCH;
      ST_ADDR:    state_next = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (mem_ready)    state_next = ST_LOAD_WB;
        else if (timeout) state_next = ST_TRAP;
      end
      ST_LOAD_WB: state_next = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_ready)    state_next = ST_FETCH;
        else if (timeout) state_next = ST_TRAP;
      end
      ST_BRANCH:  state_next = ST_FETCH;
      ST_JAL:     state_next = ST_FETCH;
      ST_TRAP:    state_next = ST_TRAP;
      default:    state_next = ST_TRAP;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = ADDR_PC;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    case (state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        addr_sel  = ADDR_PC;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_src    = PC_ALU;
        // IR load and PC+4 happen only on the completing cycle
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_EXEC: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_ALUOUT;
      end
      ST_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_ALUOUT;
      end
      ST_LOAD_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEM;
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = ADDR_ALUOUT;
      end
      ST_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        pc_src        = PC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      ST_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = PC_ALUOUT;
      end
      default: begin
      end
    endcase
  end

  // TRAP is absorbing, so the flag only needs setting, never clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (state_next == ST_TRAP) begin
      illegal <= 1'b1;
    end
  end

  assign state_dbg = state;

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != ST_IDLE && state != ST_TRAP) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (state_next == ST_FETCH && state != ST_IDLE && state != ST_FETCH) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes per-cycle expected outputs, a negedge monitor compares.
module tb_mc_ctrl_fsm;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'b0010011;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b, alu_op;
  logic        reg_write, illegal;
  logic [3:0]  state_dbg;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal),
`ifdef MC_CTRL_PERF_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state_dbg(state_dbg)
  );

  localparam logic [6:0] I_ALU = 7'b0010011, I_LD = 7'b0000011, I_ST = 7'b0100011;
  localparam logic [6:0] I_BR  = 7'b1100011, I_JAL = 7'b1101111, I_LUI = 7'b0110111;

  typedef struct packed {
    logic [21:0] vec;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  int     pc_upd = 0;
  logic [31:0] exp_cyc = 0, exp_ret = 0;
  state_t prev_st = ST_IDLE;

  // expected output vector straight from the state table
  function automatic logic [21:0] exp_vec(input state_t st, input logic mr);
    logic req, we, as, irw, pcw, pcc, rw, ill;
    logic [1:0] ps, wb, sa, sb, op;
    {req, we, as, irw, pcw, pcc, rw, ill} = '0;
    {ps, wb, sa, sb, op} = '0;
    case (st)
      ST_FETCH:   begin req = 1; irw = mr; pcw = mr; sb = 2'd1; end
      ST_DECODE:  begin sa = 2'd2; sb = 2'd2; end
      ST_EXEC:    begin sa = 2'd1; sb = 2'd2; op = 2'd2; end
      ST_ALU_WB:  begin rw = 1; end
      ST_ADDR:    begin sa = 2'd1; sb = 2'd2; end
      ST_MEM_RD:  begin req = 1; as = 1; end
      ST_LOAD_WB: begin rw = 1; wb = 2'd1; end
      ST_MEM_WR:  begin req = 1; we = 1; as = 1; end
      ST_BRANCH:  begin sa = 2'd1; op = 2'd1; ps = 2'd1; pcc = 1; end
      ST_JAL:     begin rw = 1; wb = 2'd2; pcw = 1; ps = 2'd1; end
      ST_TRAP:    begin ill = 1; end
      default:    begin end
    endcase
    return {req, we, as, irw, pcw, pcc, ps, rw, wb, sa, sb, op, ill, 4'(st)};
  endfunction

  // one clock of stimulus: drive inputs just after the edge and queue this cycle's expectation
  task automatic cyc(input state_t st, input logic mr, input logic br, input logic [6:0] op,
                     input logic rn);
    exp_t e;
    @(posedge clk); #1;
    rst_n = rn; mem_ready = mr; br_taken = br; opcode = op;
    if (!rn) begin
      exp_cyc = 0;
      exp_ret = 0;
    end else begin
      if (prev_st != ST_IDLE && prev_st != ST_TRAP) exp_cyc = exp_cyc + 1;
      if (st == ST_FETCH && prev_st != ST_IDLE && prev_st != ST_FETCH) exp_ret = exp_ret + 1;
    end
    prev_st = st;
    e.vec = exp_vec(st, mr);
    e.cyc = exp_cyc;
    e.ret = exp_ret;
    q.push_back(e);
  endtask

  task automatic do_reset();
    cyc(ST_IDLE, 1'b0, 1'b0, I_ALU, 1'b0);
    cyc(ST_IDLE, 1'b1, 1'b0, I_ALU, 1'b1);
  endtask

  task automatic f(input logic mr, input logic [6:0] op);
    cyc(ST_FETCH, mr, 1'b0, op, 1'b1);
  endtask

  task automatic s(input state_t st, input logic mr, input logic [6:0] op);
    cyc(st, mr, 1'b0, op, 1'b1);
  endtask

  task automatic check_pc(input string name, input int want);
    @(negedge clk); #1;
    checks++;
    if (pc_upd != want) begin
      errors++;
      $display("FAIL %s pc updates got %0d want %0d", name, pc_upd, want);
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] act;
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_write_cond, pc_src, reg_write,
             wb_sel, alu_src_a, alu_src_b, alu_op, illegal, state_dbg};
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL outputs t=%0t got %h want %h", $time, act, e.vec);
      end
`ifdef MC_CTRL_PERF_EN
      checks++;
      if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
        errors++;
        $display("FAIL perf t=%0t got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                 $time, cycle_cnt, instret_cnt, e.cyc, e.ret);
      end
`endif
    end
    pc_upd = pc_upd + int'(pc_write | (pc_write_cond & br_taken));
  end

  initial begin
    do_reset();
    // ALU op, zero-wait
    f(1, I_ALU); s(ST_DECODE, 1, I_ALU); s(ST_EXEC, 1, I_ALU); s(ST_ALU_WB, 1, I_ALU);
    // LOAD with three wait cycles in MEM_RD
    f(1, I_LD); s(ST_DECODE, 1, I_LD); s(ST_ADDR, 1, I_LD);
    s(ST_MEM_RD, 0, I_LD); s(ST_MEM_RD, 0, I_LD); s(ST_MEM_RD, 0, I_LD);
    s(ST_MEM_RD, 1, I_LD); s(ST_LOAD_WB, 1, I_LD);
    // STORE straight into the next FETCH
    f(1, I_ST); s(ST_DECODE, 1, I_ST); s(ST_ADDR, 1, I_ST); s(ST_MEM_WR, 1, I_ST);
    // branch not taken then taken
    f(1, I_BR); pc_upd = 0; s(ST_DECODE, 1, I_BR); cyc(ST_BRANCH, 1, 1'b0, I_BR, 1'b1);
    check_pc("branch_not_taken", 1);
    f(1, I_BR); pc_upd = 0; s(ST_DECODE, 1, I_BR); cyc(ST_BRANCH, 1, 1'b1, I_BR, 1'b1);
    check_pc("branch_taken", 2);
    // JAL
    f(1, I_JAL); s(ST_DECODE, 1, I_JAL); s(ST_JAL, 1, I_JAL);
    // mem_ready in the timeout cycle still completes the fetch
    for (int i = 0; i < 6; i++) f(0, I_ALU);
    f(1, I_ALU); s(ST_DECODE, 1, I_ALU); s(ST_EXEC, 1, I_ALU); s(ST_ALU_WB, 1, I_ALU);
    // fetch timeout
    for (int i = 0; i < 7; i++) f(0, I_ALU);
    for (int i = 0; i < 3; i++) s(ST_TRAP, 1, I_ALU);
    do_reset();
    // unsupported opcode traps and stays sticky
    f(1, I_LUI); s(ST_DECODE, 1, I_LUI);
    for (int i = 0; i < 100; i++) s(ST_TRAP, logic'(i % 2), I_LUI);
    do_reset();
    // async reset in the middle of a store wait
    f(1, I_ST); s(ST_DECODE, 1, I_ST); s(ST_ADDR, 1, I_ST);
    s(ST_MEM_WR, 0, I_ST); s(ST_MEM_WR, 0, I_ST);
    cyc(ST_IDLE, 1'b0, 1'b0, I_ST, 1'b0);
    cyc(ST_IDLE, 1'b1, 1'b0, I_ALU, 1'b1);
    f(1, I_ALU); s(ST_DECODE, 1, I_ALU); s(ST_EXEC, 1, I_ALU); s(ST_ALU_WB, 1, I_ALU);
    f(0, I_ALU);
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
